// File: rtl/match_ctrl_pkg.sv
// Shared pong match definitions: FSM state encoding, winner codes, default match length.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package match_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SERVE     = 2'd1,
        ST_PLAY      = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    localparam int WIN_SCORE_DEF = 5;

endpackage

// File: rtl/match_ctrl_if.sv
// Match controller signal bundle: game-side event inputs and match status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all inputs are levels or single-cycle pulses.
// master: game logic / keys (drives game_tick, start, point_p1, point_p2).
// slave : match_ctrl (drives score_1, score_2, round_rst, play_en, game_over, winner).
interface match_ctrl_if;
    logic       game_tick;
    logic       start;
    logic       point_p1;
    logic       point_p2;
    logic [3:0] score_1;
    logic [3:0] score_2;
    logic       round_rst;
    logic       play_en;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output game_tick, start, point_p1, point_p2,
        input  score_1, score_2, round_rst, play_en, game_over, winner
    );

    modport slave (
        input  game_tick, start, point_p1, point_p2,
        output score_1, score_2, round_rst, play_en, game_over, winner
    );
endinterface

// File: rtl/match_ctrl_rise_detect.sv
// Rising-edge detector: previous-sample register, pulse = din & ~previous sample.
// Latency: pulse is valid in the same cycle din first reads high (acted on at the next clk edge).
// Backpressure: none. Ports: clk, rst (async, active-high), din, pulse.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic prev_q;

    // prev_q resets low so an input already high at reset release is seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= din;
    end

    assign pulse = din & ~prev_q;
endmodule

// File: rtl/match_ctrl.sv
// Pong match controller: IDLE -> SERVE -> PLAY -> (SERVE | GAME_OVER), keeps scores and winner.
// Latency: one clk from a detected edge / serve expiry to the registered outputs.
// Backpressure: none. Ports: clk, rst (async, active-high), mif (match_ctrl_if.slave).
module match_ctrl
    import match_ctrl_pkg::*;
#(
    parameter int WIN_SCORE   = WIN_SCORE_DEF,
    parameter int SERVE_TICKS = 1000
) (
    input  logic         clk,
    input  logic         rst,
    match_ctrl_if.slave  mif
);
    localparam logic [3:0]  WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [15:0] SERVE_END = 16'(SERVE_TICKS);

    logic start_re, p1_re, p2_re;

    rise_detect u_start_re (.clk(clk), .rst(rst), .din(mif.start),    .pulse(start_re));
    rise_detect u_p1_re    (.clk(clk), .rst(rst), .din(mif.point_p1), .pulse(p1_re));
    rise_detect u_p2_re    (.clk(clk), .rst(rst), .din(mif.point_p2), .pulse(p2_re));

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  s1_q, s1_d, s2_q, s2_d;
    winner_t     win_q, win_d;
    logic        round_rst_q, round_rst_d;
    logic        play_en_q, play_en_d;
    logic        game_over_q, game_over_d;
    logic [3:0]  s1_inc, s2_inc;

    assign s1_inc = s1_q + 4'd1;
    assign s2_inc = s2_q + 4'd1;

    // State, serve counter, scores and all outputs are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            win_q       <= WIN_NONE;
            round_rst_q <= 1'b1;
            play_en_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            win_q       <= win_d;
            round_rst_q <= round_rst_d;
            play_en_q   <= play_en_d;
            game_over_q <= game_over_d;
        end
    end

    // Next state plus the datapath updates that ride on each transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                s1_d  = '0;
                s2_d  = '0;
                win_d = WIN_NONE;
                if (start_re) begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end
            end
            ST_SERVE: begin
                // Comparing before counting makes SERVE_TICKS=0 leave on the next clk.
                if (cnt_q == SERVE_END) state_d = ST_PLAY;
                else if (mif.game_tick) cnt_d = cnt_q + 16'd1;
            end
            ST_PLAY: begin
                if (p1_re && p2_re) begin
                    // Tie: replay the rally, nobody scores.
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end else if (p1_re && s1_q < WIN_VAL) begin
                    s1_d = s1_inc;
                    if (s1_inc == WIN_VAL) begin
                        state_d = ST_GAME_OVER;
                        win_d   = WIN_P1;
                    end else begin
                        state_d = ST_SERVE;
                        cnt_d   = '0;
                    end
                end else if (p2_re && s2_q < WIN_VAL) begin
                    s2_d = s2_inc;
                    if (s2_inc == WIN_VAL) begin
                        state_d = ST_GAME_OVER;
                        win_d   = WIN_P2;
                    end else begin
                        state_d = ST_SERVE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (start_re) begin
                    s1_d    = '0;
                    s2_d    = '0;
                    win_d   = WIN_NONE;
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from the next state so the registered copies line up with state_q.
    always_comb begin
        round_rst_d = (state_d != ST_PLAY);
        play_en_d   = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_GAME_OVER);
    end

    assign mif.score_1   = s1_q;
    assign mif.score_2   = s2_q;
    assign mif.winner    = win_q;
    assign mif.round_rst = round_rst_q;
    assign mif.play_en   = play_en_q;
    assign mif.game_over = game_over_q;
endmodule
